cpumc_arb: RTL and testbench
============================

# cpumc_arb

Sequential owner arbiter for the CPU memory controller (cpumc) bus, shared by three masters: debugger (dbg), sprite DMA (sprdma) and CPU. It grants bus ownership in fixed priority dbg > dma > cpu, and moves ownership only at transaction boundaries. A one-cycle quiet handoff separates owners. The CPU is stalled through its READY input whenever it does not own the bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: watchdog limit in cycles (used only with CPUMC_ARB_WDT_EN).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- dbg_own_in  in  1  dbg requests ownership (level; dbg active)
- dma_own_in  in  1  sprdma requests ownership (level; sprdma active)
- dbg_a_in / dma_a_in / cpu_a_in  in  16 each  master addresses
- dbg_d_in / dma_d_in / cpu_d_in  in  8 each  master write data
- dbg_r_nw_in / dma_r_nw_in / cpu_r_nw_in  in  1 each  master R/!W
- dbg_req_in / dma_req_in / cpu_req_in  in  1 each  master memory strobes
- dbg_erase_in  in  1  erase request (dbg only)
- cpumc_rdy_in  in  1  cpumc idle/ready
- cpumc_a_out  out  16  muxed address
- cpumc_d_out  out  8  muxed write data
- cpumc_r_nw_out  out  1  muxed R/!W
- cpumc_req_out  out  1  muxed strobe
- cpumc_erase_out  out  1  muxed erase
- grant_out  out  3  one-hot owner: [2]=dbg, [1]=dma, [0]=cpu
- cpu_ready_out  out  1  CPU READY
- wdt_err_out  out  1  watchdog pulse

## Operation
- States: OWN_CPU, OWN_DMA, OWN_DBG, HANDOFF. The state register also holds next_owner (2 bits).
- Reset state is OWN_CPU. Reset values: grant_out=3'b001, cpu_ready_out=1, wdt_err_out=0, cpumc_req_out=0, cpumc_erase_out=0.
- While rst is high, cpumc_req_out is forced to 0.
- Muxed bus outputs are combinational from the registered owner.
- In HANDOFF: cpumc_req_out=0, cpumc_erase_out=0, grant_out=0, cpu_ready_out=0.
- erase passes only when the owner is dbg. Otherwise it is 0.
- Desired owner = dbg if dbg_own_in, else dma if dma_own_in, else cpu.
- Switch condition: desired owner differs from the current owner, AND cpumc_rdy_in=1, AND the current owner's req_in=0.
- On the switch condition: go to HANDOFF and latch next_owner. HANDOFF always lasts exactly one cycle, then enters OWN_<next_owner>.
- If the desired owner changes during HANDOFF, next_owner is still honoured. The new owner re-arbitrates from its own state.
- Preemption: dbg preempts dma at dma's next boundary. dma resumes after dbg releases if dma_own_in is still high.
- Simultaneous dbg and dma requests: dbg wins.
- cpu_ready_out=1 only in OWN_CPU with no pending higher request.
- Mid-operation async reset: return immediately to OWN_CPU. An in-flight cpumc transaction is abandoned (cpumc is reset by the same rst).

## Timing
- A request raised at edge N while the CPU owner is idle: cpu_ready_out falls at N+1 (state moves to HANDOFF), grant_out to the new owner at N+2.
- A busy owner (req_in=1 or cpumc_rdy_in=0) delays the switch cycle by cycle until the boundary.
- Release (own_in low) at edge N: HANDOFF at N+1, CPU owns with cpu_ready_out=1 at N+2.
- grant_out and cpu_ready_out are registered. Bus mux output delay equals one combinational mux.

## Configuration
- CPUMC_ARB_WDT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles in OWN_DMA/OWN_DBG with cpumc_rdy_in=0. It clears on cpumc_rdy_in=1 or on ownership change.
  - When the count reaches TIMEOUT_CYCLES: forced HANDOFF to cpu, ignoring the req_in boundary; wdt_err_out pulses 1 cycle.
  - The offending master's own_in is masked until it deasserts.
- Not defined: no counter, wdt_err_out tied 0, no mask logic.

## Structure
- Package cpumc_arb_pkg:
  - state enum (OWN_CPU, OWN_DMA, OWN_DBG, HANDOFF)
  - owner codes (OWNER_CPU=0, OWNER_DMA=1, OWNER_DBG=2)
  - grant one-hot constants
- Sub-module: cpumc_arb_wdt, containing the counter, mask and pulse. It is instantiated only under CPUMC_ARB_WDT_EN.

## Test plan
- Reset release, no requests, cpu_req_in pulses at A=16'h8000 -> grant_out=3'b001, cpu_ready_out=1, cpumc_a_out=16'h8000, cpumc_req_out tracks cpu_req_in.
- dma_own_in rises at edge 10 with CPU idle -> cpu_ready_out=0 at 11; grant_out=3'b010 at 12; cpumc_a_out=dma_a_in=16'h2004.
- dma_own_in and dbg_own_in rise together -> grant_out=3'b100. When dbg releases with dma still requesting, one HANDOFF cycle, then 3'b010.
- dbg_own_in rises while dma_req_in=1 and cpumc_rdy_in=0 for 5 cycles -> no grant change until both clear; cpumc_req_out never 1 in HANDOFF.
- rst pulsed high mid-DMA (grant 3'b010) -> grant_out=3'b001 and cpumc_req_out=0 immediately, without waiting for a clock edge.
- With CPUMC_ARB_WDT_EN, TIMEOUT_CYCLES=8, dma owner with cpumc_rdy_in=0 held -> wdt_err_out one-cycle pulse, then CPU grant. dma_own_in is ignored until it toggles low.

Source files
------------

// File: rtl/cpumc_arb_pkg.sv
// rtl/cpumc_arb_pkg.sv - shared state, owner and grant encodings for the cpumc bus arbiter
package cpumc_arb_pkg;

    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_DMA = 2'd1,
        OWN_DBG = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    localparam logic [1:0] OWNER_CPU = 2'd0;
    localparam logic [1:0] OWNER_DMA = 2'd1;
    localparam logic [1:0] OWNER_DBG = 2'd2;

    localparam logic [2:0] GRANT_NONE = 3'b000;
    localparam logic [2:0] GRANT_CPU  = 3'b001;
    localparam logic [2:0] GRANT_DMA  = 3'b010;
    localparam logic [2:0] GRANT_DBG  = 3'b100;

    function automatic logic [2:0] state_grant(input state_t s);
        case (s)
            OWN_CPU: state_grant = GRANT_CPU;
            OWN_DMA: state_grant = GRANT_DMA;
            OWN_DBG: state_grant = GRANT_DBG;
            default: state_grant = GRANT_NONE;
        endcase
    endfunction

    function automatic state_t owner_state(input logic [1:0] o);
        case (o)
            OWNER_DMA: owner_state = OWN_DMA;
            OWNER_DBG: owner_state = OWN_DBG;
            default:   owner_state = OWN_CPU;
        endcase
    endfunction

endpackage

// File: rtl/cpumc_arb_wdt.sv
// rtl/cpumc_arb_wdt.sv - stall watchdog for dma/dbg owners: counter, own mask and error pulse
module cpumc_arb_wdt #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic owning_i,
    input  logic owner_dbg_i,
    input  logic rdy_i,
    input  logic dbg_own_i,
    input  logic dma_own_i,
    output logic dbg_own_o,
    output logic dma_own_o,
    output logic fire_o,
    output logic err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mask_dbg_q, mask_dma_q;
    logic          err_q;
    logic          stalled;

    assign stalled = owning_i && !rdy_i;
    assign fire_o  = stalled && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = '0;
        if (stalled && !fire_o) begin
            cnt_d = cnt_q + CW'(1);
        end else if (stalled) begin
            cnt_d = cnt_q;
        end
    end

    // The mask holds off a timed-out master until it drops its own request once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            mask_dbg_q <= 1'b0;
            mask_dma_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= fire_o;
            if (fire_o && owner_dbg_i) begin
                mask_dbg_q <= 1'b1;
            end else if (!dbg_own_i) begin
                mask_dbg_q <= 1'b0;
            end
            if (fire_o && !owner_dbg_i) begin
                mask_dma_q <= 1'b1;
            end else if (!dma_own_i) begin
                mask_dma_q <= 1'b0;
            end
        end
    end

    assign dbg_own_o = dbg_own_i && !mask_dbg_q;
    assign dma_own_o = dma_own_i && !mask_dma_q;
    assign err_o     = err_q;

endmodule

// File: rtl/cpumc_arb.sv
// rtl/cpumc_arb.sv - dbg > dma > cpu owner arbiter for cpumc; optional watchdog via CPUMC_ARB_WDT_EN
module cpumc_arb
    import cpumc_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_own_in,
    input  logic        dma_own_in,
    input  logic [15:0] dbg_a_in,
    input  logic [15:0] dma_a_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  dbg_d_in,
    input  logic [7:0]  dma_d_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        dbg_r_nw_in,
    input  logic        dma_r_nw_in,
    input  logic        cpu_r_nw_in,
    input  logic        dbg_req_in,
    input  logic        dma_req_in,
    input  logic        cpu_req_in,
    input  logic        dbg_erase_in,
    input  logic        cpumc_rdy_in,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out,
    output logic        cpumc_req_out,
    output logic        cpumc_erase_out,
    output logic [2:0]  grant_out,
    output logic        cpu_ready_out,
    output logic        wdt_err_out
);

    state_t      state_q, state_d;
    logic [1:0]  next_owner_q, next_owner_d;
    logic [2:0]  grant_q;
    logic        cpu_ready_q;
    logic        dbg_own_m, dma_own_m, wdt_fire;
    logic [1:0]  cur_owner, desired;
    logic        cur_req;

`ifdef CPUMC_ARB_WDT_EN
    cpumc_arb_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i       (clk),
        .rst_i       (rst),
        .owning_i    (state_q == OWN_DMA || state_q == OWN_DBG),
        .owner_dbg_i (state_q == OWN_DBG),
        .rdy_i       (cpumc_rdy_in),
        .dbg_own_i   (dbg_own_in),
        .dma_own_i   (dma_own_in),
        .dbg_own_o   (dbg_own_m),
        .dma_own_o   (dma_own_m),
        .fire_o      (wdt_fire),
        .err_o       (wdt_err_out)
    );
`else
    assign dbg_own_m   = dbg_own_in;
    assign dma_own_m   = dma_own_in;
    assign wdt_fire    = 1'b0;
    assign wdt_err_out = 1'b0;
`endif

    assign desired = dbg_own_m ? OWNER_DBG : (dma_own_m ? OWNER_DMA : OWNER_CPU);

    always_comb begin
        cur_owner = OWNER_CPU;
        cur_req   = cpu_req_in;
        case (state_q)
            OWN_DMA: begin cur_owner = OWNER_DMA; cur_req = dma_req_in; end
            OWN_DBG: begin cur_owner = OWNER_DBG; cur_req = dbg_req_in; end
            default: ;
        endcase
    end

    // Ownership only moves at a boundary: cpumc idle and the owner's strobe low.
    always_comb begin
        state_d      = state_q;
        next_owner_d = next_owner_q;
        if (state_q == HANDOFF) begin
            state_d = owner_state(next_owner_q);
        end else if (wdt_fire) begin
            state_d      = HANDOFF;
            next_owner_d = OWNER_CPU;
        end else if (desired != cur_owner && cpumc_rdy_in && !cur_req) begin
            state_d      = HANDOFF;
            next_owner_d = desired;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OWN_CPU;
            next_owner_q <= OWNER_CPU;
            grant_q      <= GRANT_CPU;
            cpu_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            next_owner_q <= next_owner_d;
            grant_q      <= state_grant(state_d);
            cpu_ready_q  <= (state_d == OWN_CPU) && (desired == OWNER_CPU);
        end
    end

    always_comb begin
        cpumc_a_out    = cpu_a_in;
        cpumc_d_out    = cpu_d_in;
        cpumc_r_nw_out = cpu_r_nw_in;
        case (cur_owner)
            OWNER_DMA: begin
                cpumc_a_out    = dma_a_in;
                cpumc_d_out    = dma_d_in;
                cpumc_r_nw_out = dma_r_nw_in;
            end
            OWNER_DBG: begin
                cpumc_a_out    = dbg_a_in;
                cpumc_d_out    = dbg_d_in;
                cpumc_r_nw_out = dbg_r_nw_in;
            end
            default: ;
        endcase
    end

    assign cpumc_req_out   = !rst && (state_q != HANDOFF) && cur_req;
    assign cpumc_erase_out = (state_q == OWN_DBG) && dbg_erase_in;
    assign grant_out       = grant_q;
    assign cpu_ready_out   = cpu_ready_q;

endmodule

// File: tb/tb_cpumc_arb.sv
// tb/tb_cpumc_arb.sv - directed and randomized checks of cpumc_arb against an owner/handoff model
module tb_cpumc_arb;

    localparam int TO = 8;
`ifdef CPUMC_ARB_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_own_in = 0, dma_own_in = 0;
    logic [15:0] dbg_a_in = 0, dma_a_in = 0, cpu_a_in = 0;
    logic [7:0]  dbg_d_in = 0, dma_d_in = 0, cpu_d_in = 0;
    logic        dbg_r_nw_in = 0, dma_r_nw_in = 0, cpu_r_nw_in = 0;
    logic        dbg_req_in = 0, dma_req_in = 0, cpu_req_in = 0;
    logic        dbg_erase_in = 0, cpumc_rdy_in = 1;
    logic [15:0] cpumc_a_out;
    logic [7:0]  cpumc_d_out;
    logic        cpumc_r_nw_out, cpumc_req_out, cpumc_erase_out;
    logic [2:0]  grant_out;
    logic        cpu_ready_out, wdt_err_out;

    cpumc_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .dbg_own_in(dbg_own_in), .dma_own_in(dma_own_in),
        .dbg_a_in(dbg_a_in), .dma_a_in(dma_a_in), .cpu_a_in(cpu_a_in),
        .dbg_d_in(dbg_d_in), .dma_d_in(dma_d_in), .cpu_d_in(cpu_d_in),
        .dbg_r_nw_in(dbg_r_nw_in), .dma_r_nw_in(dma_r_nw_in), .cpu_r_nw_in(cpu_r_nw_in),
        .dbg_req_in(dbg_req_in), .dma_req_in(dma_req_in), .cpu_req_in(cpu_req_in),
        .dbg_erase_in(dbg_erase_in), .cpumc_rdy_in(cpumc_rdy_in),
        .cpumc_a_out(cpumc_a_out), .cpumc_d_out(cpumc_d_out),
        .cpumc_r_nw_out(cpumc_r_nw_out), .cpumc_req_out(cpumc_req_out),
        .cpumc_erase_out(cpumc_erase_out), .grant_out(grant_out),
        .cpu_ready_out(cpu_ready_out), .wdt_err_out(wdt_err_out)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: owner 0=cpu 1=dma 2=dbg, plus a one-cycle handoff flag.
    int m_owner, m_next, m_cnt;
    bit m_hand, m_ready, m_err, m_mask_dma, m_mask_dbg;

    function automatic logic req_of(input int o);
        return (o == 2) ? dbg_req_in : (o == 1) ? dma_req_in : cpu_req_in;
    endfunction
    function automatic logic [15:0] a_of(input int o);
        return (o == 2) ? dbg_a_in : (o == 1) ? dma_a_in : cpu_a_in;
    endfunction
    function automatic logic [7:0] d_of(input int o);
        return (o == 2) ? dbg_d_in : (o == 1) ? dma_d_in : cpu_d_in;
    endfunction
    function automatic logic rnw_of(input int o);
        return (o == 2) ? dbg_r_nw_in : (o == 1) ? dma_r_nw_in : cpu_r_nw_in;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_next = 0; m_cnt = 0;
        m_hand = 0; m_ready = 1; m_err = 0; m_mask_dma = 0; m_mask_dbg = 0;
    endtask

    task automatic model_edge();
        int  want, cnt_n;
        bit  stalled, fire;
        want    = (dbg_own_in && !m_mask_dbg) ? 2 : (dma_own_in && !m_mask_dma) ? 1 : 0;
        stalled = !m_hand && m_owner != 0 && !cpumc_rdy_in;
        fire    = WDT && stalled && m_cnt == TO;
        cnt_n   = stalled ? ((m_cnt < TO) ? m_cnt + 1 : m_cnt) : 0;
        if (fire && m_owner == 2) m_mask_dbg = 1; else if (!dbg_own_in) m_mask_dbg = 0;
        if (fire && m_owner == 1) m_mask_dma = 1; else if (!dma_own_in) m_mask_dma = 0;
        m_err = fire;
        m_cnt = cnt_n;
        if (m_hand) begin
            m_owner = m_next;
            m_hand  = 0;
        end else if (fire) begin
            m_hand = 1; m_next = 0;
        end else if (want != m_owner && cpumc_rdy_in && !req_of(m_owner)) begin
            m_hand = 1; m_next = want;
        end
        m_ready = !m_hand && m_owner == 0 && want == 0;
    endtask

    task automatic compare_all();
        check("grant", grant_out, m_hand ? 0 : (1 << m_owner));
        check("cpu_ready", cpu_ready_out, m_ready);
        check("wdt_err", wdt_err_out, m_err);
        check("req", cpumc_req_out, m_hand ? 1'b0 : req_of(m_owner));
        check("erase", cpumc_erase_out, !m_hand && m_owner == 2 && dbg_erase_in);
        if (!m_hand) begin
            check("addr", cpumc_a_out, a_of(m_owner));
            check("wdata", cpumc_d_out, d_of(m_owner));
            check("r_nw", cpumc_r_nw_out, rnw_of(m_owner));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_bus();
        dbg_a_in = 16'($urandom); dma_a_in = 16'($urandom); cpu_a_in = 16'($urandom);
        dbg_d_in = 8'($urandom);  dma_d_in = 8'($urandom);  cpu_d_in = 8'($urandom);
        dbg_r_nw_in = 1'($urandom); dma_r_nw_in = 1'($urandom); cpu_r_nw_in = 1'($urandom);
        dbg_req_in = 1'($urandom); dma_req_in = 1'($urandom); cpu_req_in = 1'($urandom);
        dbg_erase_in = 1'($urandom);
        cpumc_rdy_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) dbg_own_in = ~dbg_own_in;
        if ($urandom_range(0, 9) == 0)  dma_own_in = ~dma_own_in;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int errs;
        model_reset();
        cpu_req_in = 1;
        repeat (2) @(negedge clk);
        check("rst_grant", grant_out, 3'b001);
        check("rst_ready", cpu_ready_out, 1'b1);
        check("rst_req", cpumc_req_out, 1'b0);
        check("rst_erase", cpumc_erase_out, 1'b0);
        check("rst_wdt", wdt_err_out, 1'b0);
        cpu_req_in = 0;
        rst = 0;

        cpu_a_in = 16'h8000;
        for (int i = 0; i < 6; i++) begin
            cpu_req_in = i[0];
            step();
            check("t1_addr", cpumc_a_out, 16'h8000);
            check("t1_req", cpumc_req_out, i[0]);
        end

        cpu_req_in = 0; dma_a_in = 16'h2004; dma_own_in = 1;
        step();
        check("t2_ready_fall", cpu_ready_out, 1'b0);
        check("t2_handoff", grant_out, 3'b000);
        step();
        check("t2_grant", grant_out, 3'b010);
        check("t2_addr", cpumc_a_out, 16'h2004);

        dma_own_in = 0;
        step();
        check("t3_rel_hand", grant_out, 3'b000);
        step();
        check("t3_rel_cpu", grant_out, 3'b001);
        check("t3_rel_ready", cpu_ready_out, 1'b1);
        dbg_own_in = 1; dma_own_in = 1;
        step(); step();
        check("t3_dbg_wins", grant_out, 3'b100);
        dbg_own_in = 0;
        step();
        check("t3_dbg_rel", grant_out, 3'b000);
        step();
        check("t3_dma_back", grant_out, 3'b010);

        dma_req_in = 1; cpumc_rdy_in = 0; dbg_own_in = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold", grant_out, 3'b010);
        end
        dma_req_in = 0; cpumc_rdy_in = 1;
        step();
        check("t4_hand", grant_out, 3'b000);
        check("t4_hand_req", cpumc_req_out, 1'b0);
        step();
        check("t4_dbg", grant_out, 3'b100);
        dbg_own_in = 0; dma_own_in = 0;
        step(); step();

        for (int i = 0; i < 2000; i++) begin
            rand_bus();
            step();
        end

        dbg_own_in = 0; dma_own_in = 0; dbg_req_in = 0; dma_req_in = 0; cpu_req_in = 0;
        cpumc_rdy_in = 1;
        step();
        dma_own_in = 1;
        for (int i = 0; i < 10 && !(m_owner == 1 && !m_hand); i++) step();
        check("t5_pre_grant", grant_out, 3'b010);
        dma_req_in = 1;
        #3;
        check("t5_pre_req", cpumc_req_out, 1'b1);
        rst = 1;
        #1;
        check("t5_async_grant", grant_out, 3'b001);
        check("t5_async_req", cpumc_req_out, 1'b0);
        check("t5_async_ready", cpu_ready_out, 1'b1);
        @(negedge clk);
        rst = 0; dma_own_in = 0; dma_req_in = 0;
        model_reset();
        step(); step();

        if (WDT) begin
            dma_own_in = 1; cpumc_rdy_in = 1;
            for (int i = 0; i < 10 && !(m_owner == 1 && !m_hand); i++) step();
            cpumc_rdy_in = 0; dma_req_in = 1;
            errs = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (wdt_err_out) errs++;
            end
            check("t6_wdt_pulses", errs, 1);
            check("t6_cpu_grant", grant_out, 3'b001);
            dma_own_in = 0;
            step();
            dma_own_in = 1; cpumc_rdy_in = 1; dma_req_in = 0;
            step(); step();
            check("t6_dma_again", grant_out, 3'b010);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
